dg_cmd_arb: RTL and testbench

DG_CMD_ARB -- requirements
Module: dg_cmd_arb

---
 rtl/dg_pkg.sv | 14 +
 rtl/dg_cmd_arb_if.sv | 33 +++
 rtl/dg_rr_pick.sv | 31 +++
 rtl/dg_cmd_arb.sv | 121 ++++++++++++
 tb/tb_dg_cmd_arb.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dg_pkg.sv
// Shared constants for the command-fetch arbiter: default geometry and the
// width/limit of the per-port grant counters.
package dg_pkg;

    localparam int DG_N_PORT = 4;
    localparam int DG_DATA_W = 32;
    localparam int DG_ADDR_W = 10;
    localparam int DG_CNT_W  = 16;

    typedef logic [DG_CNT_W-1:0] cnt_t;

    localparam cnt_t DG_CNT_MAX = '1;

endpackage

// File: rtl/dg_cmd_arb_if.sv
// Bundle of the requester-side and SRAM-side signals of the command arbiter.
// The arbiter connects through the slave modport; whoever drives requests and
// models the SRAM uses the master modport.
interface dg_cmd_arb_if
    import dg_pkg::*;
#(
    parameter int N_PORT = DG_N_PORT,
    parameter int DATA_W = DG_DATA_W,
    parameter int ADDR_W = DG_ADDR_W
);

    logic                       i_en;
    logic [N_PORT-1:0]          i_req;
    logic [N_PORT*ADDR_W-1:0]   i_addr;
    logic [N_PORT-1:0]          o_gnt;
    logic [N_PORT-1:0]          o_rvld;
    logic [DATA_W-1:0]          o_rdata;
    logic                       o_sram_rden;
    logic [ADDR_W-1:0]          o_sram_addr;
    logic [DATA_W-1:0]          i_sram_data;
    logic [N_PORT*DG_CNT_W-1:0] o_gnt_cnt;

    modport slave (
        input  i_en, i_req, i_addr, i_sram_data,
        output o_gnt, o_rvld, o_rdata, o_sram_rden, o_sram_addr, o_gnt_cnt
    );

    modport master (
        output i_en, i_req, i_addr, i_sram_data,
        input  o_gnt, o_rvld, o_rdata, o_sram_rden, o_sram_addr, o_gnt_cnt
    );

endinterface

// File: rtl/dg_rr_pick.sv
// Combinational round-robin picker: scans the eligible vector starting at the
// pointer and wrapping, returning the first hit as a one-hot winner.
module dg_rr_pick #(
    parameter int N_PORT = 4,
    parameter int PTR_W  = 2
) (
    input  logic [N_PORT-1:0] i_elig,
    input  logic [PTR_W-1:0]  i_ptr,
    output logic [N_PORT-1:0] o_win,
    output logic              o_vld
);

    // Walk the ports in priority order ptr, ptr+1, ... and keep the first eligible one
    always_comb begin
        int idx;
        idx   = 0;
        o_win = '0;
        o_vld = 1'b0;
        for (int i = 0; i < N_PORT; i++) begin
            idx = int'(i_ptr) + i;
            if (idx >= N_PORT) begin
                idx = idx - N_PORT;
            end
            if (!o_vld && i_elig[idx]) begin
                o_win[idx] = 1'b1;
                o_vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dg_cmd_arb.sv
// Round-robin arbiter letting several command-fetch requesters share one
// single-cycle-latency command SRAM. A grant issues the SRAM read, the port ID
// then rides a two-stage pipeline so the returned word is tagged with its
// owner. A port stays busy while its read is in flight.
module dg_cmd_arb
    import dg_pkg::*;
#(
    parameter int N_PORT = DG_N_PORT,
    parameter int DATA_W = DG_DATA_W,
    parameter int ADDR_W = DG_ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    dg_cmd_arb_if.slave  bus
);

    localparam int PTR_W = (N_PORT > 1) ? $clog2(N_PORT) : 1;

    logic [PTR_W-1:0]                 ptr_q, ptr_d;
    logic [N_PORT-1:0]                pid1_q, pid1_d;
    logic [N_PORT-1:0]                pid2_q, pid2_d;
    logic [N_PORT-1:0]                rvld_q, rvld_d;
    logic [DATA_W-1:0]                rdata_q, rdata_d;
    logic                             rden_q, rden_d;
    logic [ADDR_W-1:0]                addr_q, addr_d;
    logic [N_PORT-1:0][DG_CNT_W-1:0]  cnt_q, cnt_d;

    logic [N_PORT-1:0]                busy;
    logic [N_PORT-1:0]                eligible;
    logic [N_PORT-1:0]                win_oh;
    logic                             win_vld;
    logic [PTR_W-1:0]                 win_idx;
    logic [ADDR_W-1:0]                win_addr;

    // A port is busy from its grant cycle until its data-valid cycle
    always_comb begin
        busy     = pid1_q | pid2_q;
        eligible = bus.i_req & ~busy & {N_PORT{bus.i_en}};
    end

    dg_rr_pick #(
        .N_PORT (N_PORT),
        .PTR_W  (PTR_W)
    ) u_pick (
        .i_elig (eligible),
        .i_ptr  (ptr_q),
        .o_win  (win_oh),
        .o_vld  (win_vld)
    );

    // Turn the one-hot winner into an index and select its address
    always_comb begin
        win_idx  = '0;
        win_addr = '0;
        for (int k = 0; k < N_PORT; k++) begin
            if (win_oh[k]) begin
                win_idx  = PTR_W'(k);
                win_addr = bus.i_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // Next-state: issue the read, advance the port-ID pipeline, capture data, count grants
    always_comb begin
        ptr_d   = ptr_q;
        pid1_d  = win_oh;
        pid2_d  = pid1_q;
        rvld_d  = pid2_q;
        rdata_d = rdata_q;
        rden_d  = win_vld;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        if (win_vld) begin
            addr_d = win_addr;
            if (win_idx == PTR_W'(N_PORT - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_idx + PTR_W'(1);
            end
        end
        if (|pid2_q) begin
            rdata_d = bus.i_sram_data;
        end
        for (int k = 0; k < N_PORT; k++) begin
            if (pid1_q[k] && (cnt_q[k] != DG_CNT_MAX)) begin
                cnt_d[k] = cnt_q[k] + DG_CNT_W'(1);
            end
        end
    end

    // State registers; reset also drops any reads still in the pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            pid1_q  <= '0;
            pid2_q  <= '0;
            rvld_q  <= '0;
            rdata_q <= '0;
            rden_q  <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            pid1_q  <= pid1_d;
            pid2_q  <= pid2_d;
            rvld_q  <= rvld_d;
            rdata_q <= rdata_d;
            rden_q  <= rden_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_gnt       = pid1_q;
    assign bus.o_rvld      = rvld_q;
    assign bus.o_rdata     = rdata_q;
    assign bus.o_sram_rden = rden_q;
    assign bus.o_sram_addr = addr_q;
    assign bus.o_gnt_cnt   = cnt_q;

endmodule

// File: tb/tb_dg_cmd_arb.sv
// Testbench for dg_cmd_arb: directed scenarios followed by random traffic.
// A cycle-stamped reference model predicts grants, returned data and
// counters into queues; an independent monitor pops and compares them.
module tb_dg_cmd_arb;
    import dg_pkg::*;

    localparam int N  = DG_N_PORT;
    localparam int AW = DG_ADDR_W;
    localparam int DW = DG_DATA_W;
    localparam int CW = DG_CNT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Free-running clock
    always #5 clk = ~clk;

    dg_cmd_arb_if #(.N_PORT(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

    dg_cmd_arb #(.N_PORT(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] sram_q;

    // SRAM with one cycle of read latency
    always @(posedge clk) begin
        if (bus.o_sram_rden) sram_q <= mem[bus.o_sram_addr];
    end
    assign bus.i_sram_data = sram_q;

    int cyc = 0;

    // Cycle number used to stamp expectations
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int            cyc;
        int            port;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    typedef struct {
        int              cyc;
        logic [N*CW-1:0] val;
    } cnt_exp_t;

    txn_t     gnt_q[$];
    txn_t     rvld_q[$];
    cnt_exp_t cnt_q[$];

    int m_ptr = 0;
    int m_last_gnt[N];
    int m_cnt[N];
    int m_gnt_now = -1;
    bit mon_on = 1'b0;
    int mon_start = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [N*AW-1:0] addr_all(input logic [AW-1:0] base);
        logic [N*AW-1:0] a;
        for (int k = 0; k < N; k++) a[k*AW +: AW] = base + AW'(k);
        return a;
    endfunction

    // Drive one cycle of inputs and advance the reference model
    task automatic applyStimulus(input logic rst_v, input logic en, input logic [N-1:0] req,
                                 input logic [N*AW-1:0] addrs);
        int       c;
        int       w;
        txn_t     t;
        cnt_exp_t ce;
        @(posedge clk);
        #1;
        c = cyc;
        rst        = rst_v;
        bus.i_en   = en;
        bus.i_req  = req;
        bus.i_addr = addrs;
        if (rst_v) begin
            while (gnt_q.size() > 0 && gnt_q[$].cyc > c) void'(gnt_q.pop_back());
            while (rvld_q.size() > 0 && rvld_q[$].cyc > c) void'(rvld_q.pop_back());
            m_ptr = 0;
            for (int k = 0; k < N; k++) begin
                m_last_gnt[k] = -100;
                m_cnt[k]      = 0;
            end
            m_gnt_now = -1;
        end else begin
            if (m_gnt_now >= 0 && m_cnt[m_gnt_now] < 65535) m_cnt[m_gnt_now]++;
            w = -1;
            for (int i = 0; i < N; i++) begin
                int p;
                p = (m_ptr + i) % N;
                if (w < 0 && req[p] && en && c >= m_last_gnt[p] + 2) w = p;
            end
            m_gnt_now = w;
            if (w >= 0) begin
                t.cyc  = c + 1;
                t.port = w;
                t.addr = addrs[w*AW +: AW];
                t.data = mem[t.addr];
                gnt_q.push_back(t);
                t.cyc  = c + 3;
                rvld_q.push_back(t);
                m_last_gnt[w] = c + 1;
                m_ptr = (w + 1) % N;
            end
        end
        ce.cyc = c + 1;
        for (int k = 0; k < N; k++) ce.val[k*CW +: CW] = CW'(m_cnt[k]);
        cnt_q.push_back(ce);
        if (!mon_on) begin
            mon_on    = 1'b1;
            mon_start = c + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b1, '0, '0);
    endtask

    task automatic do_reset(input int n);
        repeat (n) applyStimulus(1'b1, 1'b1, '0, '0);
    endtask

    // Monitor: compare every output against the model's queued expectations
    initial begin : monitor
        logic          rst_prev;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_rdata;
        txn_t          t;
        cnt_exp_t      ce;
        rst_prev  = 1'b1;
        exp_addr  = '0;
        exp_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mon_on && cyc >= mon_start) begin
                if (rst_prev) begin
                    exp_addr  = '0;
                    exp_rdata = '0;
                end
                checkOutput("gnt_onehot", 64'($countones(bus.o_gnt) <= 1), 64'd1);
                checkOutput("rvld_onehot", 64'($countones(bus.o_rvld) <= 1), 64'd1);
                if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
                    t = gnt_q.pop_front();
                    exp_addr = t.addr;
                    checkOutput("gnt", 64'(bus.o_gnt), 64'd1 << t.port);
                    checkOutput("sram_rden", 64'(bus.o_sram_rden), 64'd1);
                end else begin
                    checkOutput("gnt_idle", 64'(bus.o_gnt), 64'd0);
                    checkOutput("sram_rden_idle", 64'(bus.o_sram_rden), 64'd0);
                end
                checkOutput("sram_addr", 64'(bus.o_sram_addr), 64'(exp_addr));
                if (rvld_q.size() > 0 && rvld_q[0].cyc == cyc) begin
                    t = rvld_q.pop_front();
                    exp_rdata = t.data;
                    checkOutput("rvld", 64'(bus.o_rvld), 64'd1 << t.port);
                end else begin
                    checkOutput("rvld_idle", 64'(bus.o_rvld), 64'd0);
                end
                checkOutput("rdata", 64'(bus.o_rdata), 64'(exp_rdata));
                if (cnt_q.size() > 0 && cnt_q[0].cyc == cyc) begin
                    ce = cnt_q.pop_front();
                    checkOutput("gnt_cnt", 64'(bus.o_gnt_cnt), 64'(ce.val));
                end
            end
            rst_prev = rst;
        end
    end

    // Time limit so the run always ends
    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    // Stimulus: directed scenarios, random traffic, then drain
    initial begin : stimulus
        logic [N*AW-1:0] ra;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        bus.i_en   = 1'b0;
        bus.i_req  = '0;
        bus.i_addr = '0;
        for (int k = 0; k < N; k++) begin
            m_last_gnt[k] = -100;
            m_cnt[k]      = 0;
        end

        $display("[TB] single read from port 0 at address 0x005");
        do_reset(3);
        applyStimulus(1'b0, 1'b1, 4'b0001, addr_all(10'h005));
        idle(5);

        $display("[TB] all ports requesting continuously");
        do_reset(2);
        repeat (8) applyStimulus(1'b0, 1'b1, 4'b1111, addr_all(10'h100));
        idle(5);

        $display("[TB] pointer at 3 with ports 0 and 3 requesting");
        do_reset(2);
        applyStimulus(1'b0, 1'b1, 4'b0100, addr_all(10'h200));
        idle(3);
        repeat (3) applyStimulus(1'b0, 1'b1, 4'b1001, addr_all(10'h210));
        idle(4);

        $display("[TB] port 1 holding its request");
        repeat (7) applyStimulus(1'b0, 1'b1, 4'b0010, addr_all(10'h300));
        idle(4);

        $display("[TB] enable dropped after a grant");
        applyStimulus(1'b0, 1'b1, 4'b0001, addr_all(10'h320));
        repeat (4) applyStimulus(1'b0, 1'b0, 4'b1111, addr_all(10'h330));
        idle(5);

        $display("[TB] withdrawn request");
        applyStimulus(1'b0, 1'b1, 4'b0110, addr_all(10'h340));
        idle(5);

        $display("[TB] reset in the grant cycle of a read");
        applyStimulus(1'b0, 1'b1, 4'b0001, addr_all(10'h3f0));
        do_reset(2);
        applyStimulus(1'b0, 1'b1, 4'b1111, addr_all(10'h050));
        idle(5);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) ra[k*AW +: AW] = AW'($urandom);
            applyStimulus(($urandom_range(0, 149) == 0), ($urandom_range(0, 7) != 0),
                          N'($urandom), ra);
        end

        idle(6);
        checkOutput("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);
        checkOutput("rvld_queue_drained", 64'(rvld_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
